// File: rtl/smpte_pkg.sv
// smpte_pkg: bar colours, bar geometry and tolerance helpers shared by the bar checker
package smpte_pkg;
  localparam int NUM_BARS = 7;
  localparam logic [23:0] WHITE   = 24'hC0C0C0;
  localparam logic [23:0] YELLOW  = 24'hC0C000;
  localparam logic [23:0] CYAN    = 24'h00C0C0;
  localparam logic [23:0] GREEN   = 24'h00C000;
  localparam logic [23:0] MAGENTA = 24'hC000C0;
  localparam logic [23:0] RED     = 24'hC00000;
  localparam logic [23:0] BLUE    = 24'h0000C0;
  localparam logic [NUM_BARS-1:0][23:0] BAR_RGB = {BLUE, RED, MAGENTA, GREEN, CYAN, YELLOW, WHITE};
  typedef enum logic {SEARCH, CHECK} state_e;
  function automatic int unsigned bar_start(input int unsigned k, input int unsigned h);
    return k * (h / NUM_BARS);
  endfunction
  function automatic logic over_tol(input logic [7:0] a, input logic [7:0] e, input int tol);
    logic [7:0] d;
    d = a > e ? a - e : e - a;
    return int'({24'd0, d}) > tol;
  endfunction
endpackage

// File: rtl/smpte_bar_lut.sv
// smpte_bar_lut: registered expected colour for the pixel being sampled, tracked by a bar index walker
module smpte_bar_lut
  import smpte_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int XW       = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  output logic [23:0] exp_rgb
);
  logic [XW-1:0] cnt_q, cnt_d, nxt;
  logic [2:0] bar_q, bar_d;
  logic [23:0] exp_q, exp_d;
  logic [NUM_BARS-2:0][XW-1:0] bnd;
  for (genvar k = 0; k < NUM_BARS - 1; k++) begin : g_bnd
    assign bnd[k] = XW'(bar_start(k + 1, H_ACTIVE));
  end
  // bar_q is the bar of the pixel at position cnt_q; it steps when the next position hits a boundary
  always_comb begin
    nxt = &cnt_q ? cnt_q : cnt_q + XW'(1);
    cnt_d = de ? nxt : '0;
    bar_d = !de ? '0 : (bar_q != 3'(NUM_BARS - 1) && nxt == bnd[bar_q]) ? bar_q + 3'd1 : bar_q;
    exp_d = BAR_RGB[bar_q];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      bar_q <= '0;
      exp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      bar_q <= bar_d;
      exp_q <= exp_d;
    end
  assign exp_rgb = exp_q;
endmodule

// File: rtl/smpte_bar_checker.sv
// smpte_bar_checker: checks 75% colour bars, frame geometry and lock on an incoming RGB stream
module smpte_bar_checker
  import smpte_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int BAR_ROWS    = 480,
  parameter int TOL         = 8,
  parameter int LOCK_FRAMES = 3
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic        vid_de,
  input  logic        vid_vsync,
  input  logic [7:0]  vid_r,
  input  logic [7:0]  vid_g,
  input  logic [7:0]  vid_b,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] err_count,
  output logic [15:0] frame_count,
  output logic        locked
);
  localparam int XW = $clog2(H_ACTIVE + 1) + 1;
  localparam int YW = $clog2(V_ACTIVE + 1) + 1;
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  state_e state_q, state_d;
  logic de1_q, de1_d, vs1_q, vs1_d, vsp_q, vsp_d, de2_q, de2_d, mis_q, mis_d, rise_q, rise_d;
  logic done_q, done_d, ok_q, ok_d, geom_q, geom_d, geom_now, line_end, good, hit;
  logic [23:0] rgb1_q, rgb1_d, exp_rgb;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d, y_now;
  logic [15:0] acc_q, acc_d, err_q, err_d, cnt_q, cnt_d;
  logic [GW-1:0] run_q, run_d;
  smpte_bar_lut #(.H_ACTIVE(H_ACTIVE), .XW(XW)) u_lut (
    .clk(pixel_clk), .rst_n(pixel_rst_n), .de(vid_de), .exp_rgb(exp_rgb)
  );
  // Stage 1 registers the inputs; stage 2 holds the compare result and the delayed vsync rise
  always_comb begin
    de1_d = vid_de;
    vs1_d = vid_vsync;
    vsp_d = vs1_q;
    rgb1_d = {vid_r, vid_g, vid_b};
    de2_d = de1_q;
    rise_d = vs1_q & ~vsp_q;
    mis_d = de1_q & (over_tol(rgb1_q[23:16], exp_rgb[23:16], TOL) |
                     over_tol(rgb1_q[15:8], exp_rgb[15:8], TOL) |
                     over_tol(rgb1_q[7:0], exp_rgb[7:0], TOL));
    line_end = ~de2_q & (x_q != '0);
    geom_now = geom_q | (line_end & (x_q != XW'(H_ACTIVE)));
    y_now = line_end ? (&y_q ? y_q : y_q + YW'(1)) : y_q;
    good = (y_now == YW'(V_ACTIVE)) & ~geom_now & (acc_q == '0);
    hit = mis_q & ((rise_q ? YW'(0) : y_q) < YW'(BAR_ROWS));
    state_d = rise_q ? CHECK : state_q;
    done_d = rise_q & (state_q == CHECK);
    ok_d = done_d ? good : ok_q;
    err_d = done_d ? acc_q : err_q;
    cnt_d = done_d ? cnt_q + 16'd1 : cnt_q;
    run_d = !done_d ? run_q : !good ? '0 : (run_q == GW'(LOCK_FRAMES)) ? run_q : run_q + GW'(1);
    x_d = rise_q ? XW'(de2_q) : de2_q ? (&x_q ? x_q : x_q + XW'(1)) : '0;
    y_d = rise_q ? '0 : y_now;
    geom_d = rise_q ? 1'b0 : geom_now;
    acc_d = rise_q ? 16'(hit) : (hit & ~&acc_q) ? acc_q + 16'd1 : acc_q;
  end
  always_ff @(posedge pixel_clk or negedge pixel_rst_n)
    if (!pixel_rst_n) begin
      state_q <= SEARCH;
      de1_q <= 1'b0;
      vs1_q <= 1'b0;
      vsp_q <= 1'b0;
      rgb1_q <= '0;
      de2_q <= 1'b0;
      rise_q <= 1'b0;
      mis_q <= 1'b0;
      done_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= '0;
      cnt_q <= '0;
      run_q <= '0;
      x_q <= '0;
      y_q <= '0;
      geom_q <= 1'b0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      de1_q <= de1_d;
      vs1_q <= vs1_d;
      vsp_q <= vsp_d;
      rgb1_q <= rgb1_d;
      de2_q <= de2_d;
      rise_q <= rise_d;
      mis_q <= mis_d;
      done_q <= done_d;
      ok_q <= ok_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      x_q <= x_d;
      y_q <= y_d;
      geom_q <= geom_d;
      acc_q <= acc_d;
    end
  assign frame_done = done_q;
  assign frame_ok = ok_q;
  assign err_count = err_q;
  assign frame_count = cnt_q;
  assign locked = run_q == GW'(LOCK_FRAMES);
endmodule

// File: tb/tb_smpte_bar_checker.sv
// tb_smpte_bar_checker: frame-level model of the bar checker plus directed frames and a saturation run
module tb_smpte_bar_checker;
  localparam int H = 14, V = 6, BR = 4, TOL = 8, LF = 3;
  localparam int SH = 70000;
  localparam logic [23:0] COL [7] = '{24'hC0C0C0, 24'hC0C000, 24'h00C0C0, 24'h00C000,
                                      24'hC000C0, 24'hC00000, 24'h0000C0};
  typedef struct {
    int due;
    logic ok;
    logic [15:0] err;
    logic [15:0] cnt;
    logic lk;
  } rep_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, de, vs, done, ok, locked;
  logic [7:0] r, g, b;
  logic [15:0] err, fcnt;
  logic s_rst_n, s_de, s_vs, s_done, s_ok, s_lk;
  logic [7:0] s_r, s_g, s_b;
  logic [15:0] s_err, s_fcnt;
  smpte_bar_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_ROWS(BR), .TOL(TOL), .LOCK_FRAMES(LF)) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .vid_de(de), .vid_vsync(vs),
    .vid_r(r), .vid_g(g), .vid_b(b), .frame_done(done), .frame_ok(ok),
    .err_count(err), .frame_count(fcnt), .locked(locked)
  );
  smpte_bar_checker #(.H_ACTIVE(SH), .V_ACTIVE(1), .BAR_ROWS(1), .TOL(TOL), .LOCK_FRAMES(LF)) dut_sat (
    .pixel_clk(clk), .pixel_rst_n(s_rst_n), .vid_de(s_de), .vid_vsync(s_vs),
    .vid_r(s_r), .vid_g(s_g), .vid_b(s_b), .frame_done(s_done), .frame_ok(s_ok),
    .err_count(s_err), .frame_count(s_fcnt), .locked(s_lk)
  );
  int checks = 0, failures = 0, cyc = 0, mode = 0;
  int m_y = 0, m_err = 0, m_run = 0;
  bit m_search = 1, m_geom = 0, sat_fin = 0, got;
  logic [15:0] m_cnt = '0;
  rep_t q[$];
  logic p_ok = 0, p_lk = 0;
  logic [15:0] p_err = '0, p_cnt = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", n, a, e, cyc);
    end
  endtask
  function automatic logic [23:0] col(input int x);
    int k;
    k = x / (H / 7);
    return COL[k > 6 ? 6 : k];
  endfunction
  function automatic logic [23:0] pix(input int y, input int x);
    logic [23:0] p;
    p = col(x);
    if (mode == 1 && (((y == 1 || y == 2) && x >= 12) || (y == 3 && x == 12))) p[7:0] = 8'h00;
    if (mode == 2 && y == 0 && x == 0) p = 24'hC8C0B8;
    if (mode == 2 && y == 5 && x == 3) p = 24'hFF0000;
    if (mode == 3 && y == 0 && x == 0) p = 24'hB8B8B8;
    if (mode == 3 && y == 0 && x == 1) p = 24'hC9C0C0;
    return p;
  endfunction
  function automatic bit bad_px(input logic [23:0] a, input logic [23:0] e);
    for (int c = 0; c < 3; c++) begin
      int d;
      d = int'(a[c*8 +: 8]) - int'(e[c*8 +: 8]);
      if (d > TOL || d < -TOL) return 1;
    end
    return 0;
  endfunction
  task automatic send_line(input int len);
    logic [23:0] p;
    for (int x = 0; x < len; x++) begin
      @(posedge clk); #1;
      p = pix(m_y, x);
      de = 1'b1;
      {r, g, b} = p;
      if (!m_search && m_y < BR && bad_px(p, col(x))) m_err = m_err == 65535 ? 65535 : m_err + 1;
    end
    @(posedge clk); #1 de = 1'b0;
    if (len != H) m_geom = 1;
    m_y++;
  endtask
  task automatic frame(input int nl, input int short_y);
    for (int y = 0; y < nl; y++) send_line(y == short_y ? H - 1 : H);
  endtask
  task automatic vsync(output bit seen);
    rep_t rp;
    repeat (2) @(posedge clk);
    #1 vs = 1'b1;
    if (m_search) m_search = 0;
    else begin
      rp.ok = m_y == V && !m_geom && m_err == 0;
      m_run = rp.ok ? (m_run < LF ? m_run + 1 : LF) : 0;
      m_cnt = m_cnt + 16'd1;
      rp.err = 16'(m_err);
      rp.cnt = m_cnt;
      rp.lk = m_run == LF;
      rp.due = cyc + 3;
      q.push_back(rp);
    end
    m_y = 0;
    m_err = 0;
    m_geom = 0;
    @(posedge clk); #1 vs = 1'b0;
    seen = 0;
    repeat (6) @(negedge clk) if (done) seen = 1;
  endtask
  always @(negedge clk) begin
    bit exp_done;
    rep_t rp;
    exp_done = q.size() != 0 && q[0].due == cyc;
    chk("frame_done", done, exp_done);
    if (exp_done) begin
      rp = q.pop_front();
      p_ok = rp.ok;
      p_err = rp.err;
      p_cnt = rp.cnt;
      p_lk = rp.lk;
    end
    chk("frame_ok", ok, p_ok);
    chk("err_count", err, p_err);
    chk("frame_count", fcnt, p_cnt);
    chk("locked", locked, p_lk);
  end
  initial begin
    s_rst_n = 1; s_de = 0; s_vs = 0; s_r = 0; s_g = 0; s_b = 0;
    #2 s_rst_n = 0;
    repeat (3) @(posedge clk);
    #1 s_rst_n = 1;
    @(posedge clk); #1 s_vs = 1;
    @(posedge clk); #1 s_vs = 0;
    repeat (4) @(posedge clk);
    #1 s_de = 1;
    repeat (65600) @(posedge clk);
    #1 s_de = 0;
    repeat (4) @(posedge clk);
    #1 s_vs = 1;
    @(posedge clk); #1 s_vs = 0;
    got = 0;
    repeat (8) @(negedge clk) if (s_done) got = 1;
    chk("sat_done", got, 1);
    chk("sat_err", s_err, 16'hFFFF);
    chk("sat_ok", s_ok, 0);
    chk("sat_cnt", s_fcnt, 1);
    chk("sat_locked", s_lk, 0);
    sat_fin = 1;
  end
  initial begin
    bit sn;
    rst_n = 1; de = 0; vs = 0; r = 0; g = 0; b = 0;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    chk("rst_done", done, 0);
    chk("rst_ok", ok, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", fcnt, 0);
    chk("rst_locked", locked, 0);
    #1 rst_n = 1;
    vsync(sn);
    chk("first_vsync_silent", sn, 0);
    for (int f = 1; f <= 3; f++) begin
      frame(V, -1);
      vsync(sn);
      chk("clean_done", sn, 1);
      chk("clean_ok", ok, 1);
      chk("clean_err", err, 0);
      chk("clean_cnt", fcnt, f);
      chk("clean_locked", locked, f == 3);
    end
    mode = 1; frame(V, -1); vsync(sn);
    chk("blue_err", err, 5);
    chk("blue_ok", ok, 0);
    chk("blue_locked", locked, 0);
    mode = 3; frame(V, -1); vsync(sn);
    chk("tol_edge_err", err, 1);
    mode = 2; frame(V, -1); vsync(sn);
    chk("in_tol_err", err, 0);
    chk("in_tol_ok", ok, 1);
    mode = 0; frame(V, 2); vsync(sn);
    chk("short_line_ok", ok, 0);
    chk("short_line_err", err, 0);
    frame(V - 1, -1); vsync(sn);
    chk("five_lines_ok", ok, 0);
    chk("five_lines_err", err, 0);
    for (int f = 0; f < 3; f++) begin
      frame(V, -1);
      vsync(sn);
    end
    chk("relock", locked, 1);
    frame(3, -1);
    @(posedge clk); #1 rst_n = 0;
    q.delete();
    p_ok = 0; p_err = '0; p_cnt = '0; p_lk = 0;
    m_search = 1; m_run = 0; m_cnt = '0; m_err = 0; m_geom = 0;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_ok", ok, 0);
    chk("midrst_err", err, 0);
    chk("midrst_cnt", fcnt, 0);
    chk("midrst_locked", locked, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int y = 3; y < V; y++) send_line(H);
    vsync(sn);
    chk("post_rst_silent", sn, 0);
    frame(V, -1);
    vsync(sn);
    chk("post_rst_done", sn, 1);
    chk("post_rst_cnt", fcnt, 1);
    chk("post_rst_ok", ok, 1);
    for (int i = 0; i < 80000 && !sat_fin; i++) @(posedge clk);
    chk("sat_finished", sat_fin, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
